riscv_test_monitor: RTL and testbench

Synthesizable end-of-test monitor for riscv-tests runs on ToastCore, replacing the bench-only "finish on unimp" check. It watches the fetched instruction stream and the data-memory write port. It detects test termination by either a sentinel instruction or a riscv-tests `tohost` store, and reports pass, fail, or timeout with the failing test number. It sits beside the core in simulation and FPGA builds, so results are visible on LEDs/UART without `$finish`.

---
 rtl/riscv_test_monitor_pkg.sv | 17 +
 rtl/riscv_test_monitor_sat_counter.sv | 20 ++
 rtl/riscv_test_monitor.sv | 130 +++++++++++++
 tb/tb_riscv_test_monitor.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_test_monitor_pkg.sv
// Shared types and constants for the riscv-tests end-of-test monitor.
package riscv_test_monitor_pkg;

   typedef enum logic [2:0] {
      MON_ARM,
      MON_RUN,
      MON_PASS,
      MON_FAIL,
      MON_TIMEOUT
   } monitor_state_t;

   localparam logic [31:0] UNIMP_INSTR = 32'hc0001073;

   // riscv-tests reports success as the value 1 in gp or tohost
   localparam logic [31:0] PASS_CODE = 32'd1;

endpackage

// File: rtl/riscv_test_monitor_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge Clk) begin
      if (Reset || clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor: detects riscv-tests termination by sentinel instruction or
// tohost store and latches pass/fail/timeout with the failing test number.
module riscv_test_monitor
   import riscv_test_monitor_pkg::*;
#(
   parameter logic [31:0] SENTINEL_INSTR = UNIMP_INSTR,
   parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
   parameter logic [1:0]  MODE           = 2'b11,
   parameter int          TIMEOUT_CYCLES = 100000,
   parameter int          START_DELAY    = 4,
   parameter int          CNT_WIDTH      = 32
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 instr_valid,
   input  logic [31:0]          instr,
   input  logic [31:0]          gp_value,
   input  logic                 mem_wr_en,
   input  logic [31:0]          mem_addr,
   input  logic [31:0]          mem_wr_data,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic                 timeout,
   output logic [30:0]          test_num,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instr_count
);

   localparam int ARM_W = 32;

   monitor_state_t r_state;
   monitor_state_t w_nextState;
   logic [30:0]    r_testNum;
   logic [30:0]    w_nextTestNum;
   logic           r_done;
   logic           r_pass;
   logic           r_fail;
   logic           r_timeout;
   logic           w_countEn;
   logic [ARM_W-1:0] w_armCount;
   logic           w_armDone;
   logic           w_tohostEvent;
   logic           w_sentinelEvent;
   logic           w_timeoutHit;

   sat_counter #(.WIDTH(ARM_W)) u_armDelay (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (r_state != MON_ARM),
      .en    (r_state == MON_ARM),
      .count (w_armCount)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_cycleCount (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (1'b0),
      .en    (w_countEn),
      .count (cycle_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_instrCount (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (1'b0),
      .en    (w_countEn && instr_valid),
      .count (instr_count)
   );

   // ARM holds for START_DELAY sampled cycles; the last one hands over to RUN
   assign w_armDone       = (START_DELAY == 0) || (w_armCount >= ARM_W'(START_DELAY - 1));
   assign w_tohostEvent   = MODE[1] && mem_wr_en && (mem_addr == TOHOST_ADDR) && mem_wr_data[0];
   assign w_sentinelEvent = MODE[0] && instr_valid && (instr == SENTINEL_INSTR);
   assign w_timeoutHit    = (TIMEOUT_CYCLES != 0) &&
                            (cycle_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

   always_comb begin
      w_nextState   = r_state;
      w_nextTestNum = r_testNum;
      w_countEn     = 1'b0;
      case (r_state)
         MON_ARM: begin
            if (w_armDone) w_nextState = MON_RUN;
         end
         MON_RUN: begin
            // tohost outranks the sentinel, which outranks the watchdog
            if (w_tohostEvent) begin
               w_nextState   = (mem_wr_data == PASS_CODE) ? MON_PASS : MON_FAIL;
               w_nextTestNum = (mem_wr_data == PASS_CODE) ? '0 : mem_wr_data[31:1];
            end else if (w_sentinelEvent) begin
               w_nextState   = (gp_value == PASS_CODE) ? MON_PASS : MON_FAIL;
               w_nextTestNum = (gp_value == PASS_CODE) ? '0 : gp_value[31:1];
            end else if (w_timeoutHit) begin
               w_nextState   = MON_TIMEOUT;
            end else begin
               w_countEn     = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= MON_ARM;
         r_testNum <= '0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_fail    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_testNum <= w_nextTestNum;
         r_pass    <= (w_nextState == MON_PASS);
         r_fail    <= (w_nextState == MON_FAIL);
         r_timeout <= (w_nextState == MON_TIMEOUT);
         r_done    <= (w_nextState == MON_PASS) || (w_nextState == MON_FAIL) ||
                      (w_nextState == MON_TIMEOUT);
      end
   end

   assign done     = r_done;
   assign pass     = r_pass;
   assign fail     = r_fail;
   assign timeout  = r_timeout;
   assign test_num = r_testNum;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench: two monitor configurations share one stimulus stream; a
// first-event reference model predicts each run's verdict and frozen counters.
module tb_riscv_test_monitor;

   localparam logic [31:0] UNIMP  = 32'hc0001073;
   localparam logic [31:0] TOHOST = 32'h0000_1000;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          DELAY  = 4;

   typedef struct packed {
      logic        v;
      logic [31:0] ins;
      logic [31:0] gp;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } stim_t;

   typedef struct packed {
      logic        done;
      logic        pass;
      logic        fail;
      logic        tmo;
      logic [30:0] tn;
      logic [31:0] cyc;
      logic [31:0] ins;
   } res_t;

   logic        clk;
   logic        Reset;
   logic        instrValid;
   logic [31:0] instr;
   logic [31:0] gpValue;
   logic        memWrEn;
   logic [31:0] memAddr;
   logic [31:0] memWrData;
   logic        endOfRun;

   logic        done0, pass0, fail0, tmo0, done1, pass1, fail1, tmo1;
   logic [30:0] tn0, tn1;
   logic [31:0] cyc0, cyc1, ins0, ins1;

   res_t obs [2];
   res_t qDone [2][$];
   res_t qSnap [2][$];
   logic prevDone [2];
   int   nChecks;
   int   nPass;

   // Instance 0: both detectors, 50-cycle watchdog. Instance 1: sentinel only, no watchdog.
   riscv_test_monitor #(
      .MODE(2'b11), .TIMEOUT_CYCLES(50), .START_DELAY(DELAY), .CNT_WIDTH(32)
   ) dut (
      .Clk(clk), .Reset(Reset), .instr_valid(instrValid), .instr(instr),
      .gp_value(gpValue), .mem_wr_en(memWrEn), .mem_addr(memAddr),
      .mem_wr_data(memWrData), .done(done0), .pass(pass0), .fail(fail0),
      .timeout(tmo0), .test_num(tn0), .cycle_count(cyc0), .instr_count(ins0)
   );

   riscv_test_monitor #(
      .MODE(2'b01), .TIMEOUT_CYCLES(0), .START_DELAY(DELAY), .CNT_WIDTH(32)
   ) dutNoWd (
      .Clk(clk), .Reset(Reset), .instr_valid(instrValid), .instr(instr),
      .gp_value(gpValue), .mem_wr_en(memWrEn), .mem_addr(memAddr),
      .mem_wr_data(memWrData), .done(done1), .pass(pass1), .fail(fail1),
      .timeout(tmo1), .test_num(tn1), .cycle_count(cyc1), .instr_count(ins1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      obs[0] = {done0, pass0, fail0, tmo0, tn0, cyc0, ins0};
      obs[1] = {done1, pass1, fail1, tmo1, tn1, cyc1, ins1};
   end

   function automatic logic [1:0] modeOf(input int d);
      return (d == 0) ? 2'b11 : 2'b01;
   endfunction

   function automatic int timeoutOf(input int d);
      return (d == 0) ? 50 : 0;
   endfunction

   // Reference model: scan the RUN cycles for the first terminating condition
   function automatic res_t predict(input stim_t s[$], input logic [1:0] mode, input int tmo);
      res_t        r;
      int          nIns;
      logic        th;
      logic        se;
      logic [31:0] code;
      r    = '0;
      nIns = 0;
      for (int k = 0; k < s.size(); k++) begin
         th = mode[1] && s[k].we && (s[k].addr == TOHOST) && s[k].data[0];
         se = mode[0] && s[k].v && (s[k].ins == UNIMP);
         if (th || se) begin
            code   = th ? s[k].data : s[k].gp;
            r.done = 1'b1;
            r.pass = (code == 32'd1);
            r.fail = (code != 32'd1);
            r.tn   = (code == 32'd1) ? 31'd0 : code[31:1];
            r.cyc  = k;
            r.ins  = nIns;
            return r;
         end
         if ((tmo != 0) && (k == tmo - 1)) begin
            r.done = 1'b1;
            r.tmo  = 1'b1;
            r.cyc  = k;
            r.ins  = nIns;
            return r;
         end
         if (s[k].v) nIns++;
      end
      r.cyc = s.size();
      r.ins = nIns;
      return r;
   endfunction

   function automatic stim_t mk(input logic v, input logic [31:0] ins, input logic [31:0] gp,
                                input logic we, input logic [31:0] addr, input logic [31:0] data);
      stim_t x;
      x = {v, ins, gp, we, addr, data};
      return x;
   endfunction

   task automatic drive(input stim_t x);
      instrValid = x.v;
      instr      = x.ins;
      gpValue    = x.gp;
      memWrEn    = x.we;
      memAddr    = x.addr;
      memWrData  = x.data;
   endtask

   task automatic checkOutput(input string name, input int d, input res_t act, input res_t exp);
      nChecks++;
      if (act === exp) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s dut%0d: got done=%0b pass=%0b fail=%0b tmo=%0b tn=%0d cyc=%0d ins=%0d, want done=%0b pass=%0b fail=%0b tmo=%0b tn=%0d cyc=%0d ins=%0d",
                  name, d, act.done, act.pass, act.fail, act.tmo, act.tn, act.cyc, act.ins,
                  exp.done, exp.pass, exp.fail, exp.tmo, exp.tn, exp.cyc, exp.ins);
      end
   endtask

   // One run: reset, ARM cycles full of would-be events, then the RUN stimulus
   task automatic applyStimulus(input stim_t s[$]);
      res_t e;
      @(negedge clk);
      Reset = 1'b1;
      drive(mk(1'b0, NOP, 32'd0, 1'b0, 32'd0, 32'd0));
      @(negedge clk);
      Reset = 1'b0;
      for (int i = 0; i < DELAY; i++) begin
         drive(mk(1'b1, UNIMP, 32'd1, 1'b1, TOHOST, 32'd1));
         @(negedge clk);
      end
      for (int d = 0; d < 2; d++) begin
         e = predict(s, modeOf(d), timeoutOf(d));
         if (e.done) qDone[d].push_back(e);
         qSnap[d].push_back(e);
      end
      for (int k = 0; k < s.size(); k++) begin
         drive(s[k]);
         if (k == s.size() - 1) endOfRun = 1'b1;
         @(negedge clk);
      end
      endOfRun = 1'b0;
      drive(mk(1'b0, NOP, 32'd0, 1'b0, 32'd0, 32'd0));
   endtask

   // Monitor: compares reset state, each verdict as done rises, and end-of-run snapshots
   initial begin
      prevDone[0] = 1'b0;
      prevDone[1] = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            if (Reset) begin
               checkOutput("reset", d, obs[d], '0);
            end else begin
               if (obs[d].done && !prevDone[d]) begin
                  if (qDone[d].size() == 0) begin
                     nChecks++;
                     $display("[TB] FAIL unexpected_done dut%0d: got done=1, want done=0", d);
                  end else begin
                     checkOutput("verdict", d, obs[d], qDone[d].pop_front());
                  end
               end
               if (endOfRun && (qSnap[d].size() != 0)) begin
                  checkOutput("end_of_run", d, obs[d], qSnap[d].pop_front());
               end
            end
            prevDone[d] = obs[d].done;
         end
      end
   end

   initial begin
      stim_t s[$];
      stim_t x;
      int    len;
      nChecks  = 0;
      nPass    = 0;
      Reset    = 1'b1;
      endOfRun = 1'b0;
      drive(mk(1'b0, NOP, 32'd0, 1'b0, 32'd0, 32'd0));

      // Sentinel pass after ten NOPs
      s = {};
      for (int i = 0; i < 10; i++) s.push_back(mk(1'b1, NOP, 32'd9, 1'b0, 32'd0, 32'd0));
      s.push_back(mk(1'b1, UNIMP, 32'd1, 1'b0, 32'd0, 32'd0));
      for (int i = 0; i < 3; i++) s.push_back(mk(1'b1, UNIMP, 32'd6, 1'b1, TOHOST, 32'd3));
      applyStimulus(s);

      // tohost fail with test 5, later pass write must not override
      s = {};
      for (int i = 0; i < 3; i++) s.push_back(mk(1'b1, NOP, 32'd0, 1'b0, 32'd0, 32'd0));
      s.push_back(mk(1'b0, NOP, 32'd0, 1'b1, TOHOST, 32'h0000_000B));
      s.push_back(mk(1'b0, NOP, 32'd0, 1'b0, 32'd0, 32'd0));
      s.push_back(mk(1'b0, NOP, 32'd0, 1'b1, TOHOST, 32'd1));
      applyStimulus(s);

      // Even data and wrong address are ignored, then a real pass write
      s = {};
      s.push_back(mk(1'b1, NOP, 32'd0, 1'b1, TOHOST, 32'd2));
      s.push_back(mk(1'b1, NOP, 32'd0, 1'b1, TOHOST + 32'd4, 32'd1));
      s.push_back(mk(1'b0, NOP, 32'd0, 1'b0, 32'd0, 32'd0));
      s.push_back(mk(1'b0, NOP, 32'd0, 1'b1, TOHOST, 32'd1));
      s.push_back(mk(1'b0, NOP, 32'd0, 1'b0, 32'd0, 32'd0));
      applyStimulus(s);

      // Sentinel failing gp=7 coincides with tohost pass
      s = {};
      s.push_back(mk(1'b1, NOP, 32'd0, 1'b0, 32'd0, 32'd0));
      s.push_back(mk(1'b1, UNIMP, 32'd7, 1'b1, TOHOST, 32'd1));
      s.push_back(mk(1'b0, NOP, 32'd0, 1'b0, 32'd0, 32'd0));
      applyStimulus(s);

      // Watchdog at 50 on instance 0; instance 1 keeps running
      s = {};
      for (int i = 0; i < 60; i++) s.push_back(mk(1'b0, NOP, 32'd0, 1'b0, 32'd0, 32'd0));
      applyStimulus(s);

      // Long idle stretch: instance 1 must never time out
      s = {};
      for (int i = 0; i < 1000; i++) s.push_back(mk(1'b0, NOP, 32'd0, 1'b0, 32'd0, 32'd0));
      applyStimulus(s);

      // Twenty RUN cycles, then the next run's reset lands mid-run
      s = {};
      for (int i = 0; i < 20; i++) s.push_back(mk(1'b1, NOP, 32'd1, 1'b0, 32'd0, 32'd0));
      applyStimulus(s);

      // Randomised runs
      for (int r = 0; r < 40; r++) begin
         s   = {};
         len = $urandom_range(5, 70);
         for (int k = 0; k < len; k++) begin
            x.v    = ($urandom_range(0, 9) < 7);
            x.ins  = ($urandom_range(0, 19) == 0) ? UNIMP : $urandom;
            x.gp   = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'($urandom_range(0, 63));
            x.we   = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
               0, 1:    x.addr = TOHOST;
               2:       x.addr = TOHOST + 32'd4;
               default: x.addr = $urandom;
            endcase
            x.data = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'($urandom_range(0, 63));
            s.push_back(x);
         end
         applyStimulus(s);
      end

      @(negedge clk);
      Reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         nChecks++;
         if ((qDone[d].size() == 0) && (qSnap[d].size() == 0)) begin
            nPass++;
         end else begin
            $display("[TB] FAIL pending_expectations dut%0d: got %0d verdicts and %0d snapshots left, want 0",
                     d, qDone[d].size(), qSnap[d].size());
         end
      end
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
